clk_div_bank: RTL and testbench

- Parametrised multi-channel clock divider. Successor to the single fixed two-stage divider.
- NCH independent channels, each with a runtime-programmable divisor.
- Channels can be chained so that a slow channel counts the wraps of the channel below it.
- Each channel produces a 50% divided clock and a one-cycle tick enable. All logic runs on clk_sys; it feeds the display/scan and slow-timer logic.

---
 rtl/clk_div_bank.sv | 152 +++++++++++++++
 tb/tb_clk_div_bank.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable clock divider.
//
// Each of NCH channels counts events. An event is either one i_clk_sys cycle, or, for a chained
// channel, one tick of the channel below it. A channel wraps every D events, where D is its
// active divisor. Each wrap produces a one-cycle o_tick pulse and toggles o_clk_out, so o_clk_out
// is a 50% clock with a period of 2*D events. A new divisor is written into a pending register.
// It becomes active at the next wrap, or on the next cycle if the channel is idle.
//
// Optional feature: when CLK_DIV_BANK_SYNC_EN is defined, an extra input i_sync_rst
// phase-aligns every channel. It also applies any pending divisors immediately.
//
// Ports:
//   i_clk_sys    system clock; all state changes on its rising edge
//   i_rst_n      asynchronous active-low reset
//   i_sync_rst   (CLK_DIV_BANK_SYNC_EN only) one-cycle phase-align strobe
//   i_enable     per-channel run enable
//   i_div_wr     divisor write strobe
//   i_div_sel    channel index for i_div_wr; indices >= NCH are ignored
//   i_div_val    new divisor value; 0 parks the channel
//   o_clk_out    registered divided clocks
//   o_tick       registered one-cycle pulse at each channel wrap
//   o_div_busy   divisor written but not yet applied
module clk_div_bank #(
  parameter int unsigned    NCH          = 2,
  parameter int unsigned    CW           = 26,
  parameter logic [CW-1:0]  DEFAULT_DIV  = CW'(5001),
  parameter logic [NCH-1:0] CASCADE_MASK = NCH'(2),
  localparam int unsigned   SelW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            i_clk_sys,
  input  logic            i_rst_n,
`ifdef CLK_DIV_BANK_SYNC_EN
  input  logic            i_sync_rst,
`endif
  input  logic [NCH-1:0]  i_enable,
  input  logic            i_div_wr,
  input  logic [SelW-1:0] i_div_sel,
  input  logic [CW-1:0]   i_div_val,
  output logic [NCH-1:0]  o_clk_out,
  output logic [NCH-1:0]  o_tick,
  output logic [NCH-1:0]  o_div_busy
);

  // Registered ticks of all channels. Chained channels count these.
  logic [NCH-1:0] w_tick;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_active;
    logic [CW-1:0] r_pending;
    logic          r_clk;
    logic          r_tick;
    logic          r_busy;

    logic [CW-1:0] w_cnt_d;
    logic [CW-1:0] w_active_d;
    logic [CW-1:0] w_pending_d;
    logic          w_clk_d;
    logic          w_tick_d;
    logic          w_busy_d;

    logic          w_ev;
    logic          w_wr;
    logic          w_run;
    logic          w_wrap;
    logic          w_sync;

    // A chained stage counts the registered tick of the stage below it. This costs one cycle of
    // phase per stage, but the period is unchanged.
    if (gi > 0 && CASCADE_MASK[gi]) begin : g_casc
      assign w_ev = w_tick[gi-1];
    end else begin : g_free
      assign w_ev = 1'b1;
    end

`ifdef CLK_DIV_BANK_SYNC_EN
    assign w_sync = i_sync_rst;
`else
    assign w_sync = 1'b0;
`endif

    // Out-of-range selects match no channel, so those writes are ignored.
    assign w_wr   = i_div_wr && (i_div_sel == SelW'(gi));
    assign w_run  = i_enable[gi] && (r_active != '0);
    assign w_wrap = w_run && w_ev && (r_cnt == r_active - CW'(1));

    always_comb begin
      w_cnt_d     = r_cnt;
      w_clk_d     = r_clk;
      w_tick_d    = 1'b0;
      w_active_d  = r_active;
      w_pending_d = r_pending;
      w_busy_d    = r_busy;
      if (w_sync) begin
        // Alignment wins over wraps and over a write in the same cycle. That write is dropped.
        w_cnt_d    = '0;
        w_clk_d    = 1'b0;
        w_active_d = r_pending;
        w_busy_d   = 1'b0;
      end else begin
        if (!w_run) begin
          w_cnt_d = '0;
          w_clk_d = 1'b0;
          if (r_busy) begin
            w_active_d = r_pending;
            w_busy_d   = 1'b0;
          end
        end else if (w_wrap) begin
          // The wrap itself completes with the old divisor. The new one governs from cnt=0.
          w_cnt_d  = '0;
          w_clk_d  = ~r_clk;
          w_tick_d = 1'b1;
          if (r_busy) begin
            w_active_d = r_pending;
            w_busy_d   = 1'b0;
          end
        end else if (w_ev) begin
          w_cnt_d = r_cnt + CW'(1);
        end
        // A write coinciding with an apply stays pending. It is applied at the next wrap.
        if (w_wr) begin
          w_pending_d = i_div_val;
          w_busy_d    = 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt     <= '0;
        r_active  <= DEFAULT_DIV;
        r_pending <= DEFAULT_DIV;
        r_clk     <= 1'b0;
        r_tick    <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        r_cnt     <= w_cnt_d;
        r_active  <= w_active_d;
        r_pending <= w_pending_d;
        r_clk     <= w_clk_d;
        r_tick    <= w_tick_d;
        r_busy    <= w_busy_d;
      end
    end

    assign w_tick[gi]     = r_tick;
    assign o_tick[gi]     = r_tick;
    assign o_clk_out[gi]  = r_clk;
    assign o_div_busy[gi] = r_busy;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;
  localparam int unsigned    NCH     = 3;
  localparam int unsigned    CW      = 26;
  localparam int unsigned    DEF_DIV = 5001;
  localparam logic [NCH-1:0] CASC    = 3'b010;
  localparam int             LIMIT   = 6000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH-1:0]  enable;
  logic            div_wr;
  logic [1:0]      div_sel;
  logic [CW-1:0]   div_val;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  div_busy;
`ifdef CLK_DIV_BANK_SYNC_EN
  logic            sync_rst;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  clk_div_bank #(
    .NCH(NCH),
    .CW(CW),
    .DEFAULT_DIV(CW'(DEF_DIV)),
    .CASCADE_MASK(CASC)
  ) dut (
    .i_clk_sys(clk),
    .i_rst_n(rst_n),
`ifdef CLK_DIV_BANK_SYNC_EN
    .i_sync_rst(sync_rst),
`endif
    .i_enable(enable),
    .i_div_wr(div_wr),
    .i_div_sel(div_sel),
    .i_div_val(div_val),
    .o_clk_out(clk_out),
    .o_tick(tick),
    .o_div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per channel, an event counter, an active and a pending divisor, and the
  // visible outputs.
  int unsigned m_cnt [NCH];
  int unsigned m_act [NCH];
  int unsigned m_pend[NCH];
  bit          m_clk [NCH];
  bit          m_tick[NCH];
  bit          m_busy[NCH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i]  <= 0;
        m_act[i]  <= DEF_DIV;
        m_pend[i] <= DEF_DIV;
        m_clk[i]  <= 1'b0;
        m_tick[i] <= 1'b0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        bit ev;
        bit s;
        bit wr;
        bit run;
        ev = 1'b1;
        if (i > 0) begin
          if (CASC[i]) ev = m_tick[i-1];
        end
`ifdef CLK_DIV_BANK_SYNC_EN
        s = sync_rst;
`else
        s = 1'b0;
`endif
        wr  = div_wr && (int'(div_sel) == i);
        run = enable[i] && (m_act[i] != 0);
        if (s) begin
          m_cnt[i]  <= 0;
          m_clk[i]  <= 1'b0;
          m_tick[i] <= 1'b0;
          m_act[i]  <= m_pend[i];
          m_busy[i] <= 1'b0;
        end else begin
          if (!run) begin
            m_cnt[i]  <= 0;
            m_clk[i]  <= 1'b0;
            m_tick[i] <= 1'b0;
            if (m_busy[i]) begin
              m_act[i]  <= m_pend[i];
              m_busy[i] <= 1'b0;
            end
          end else if (ev && (m_cnt[i] + 1 == m_act[i])) begin
            m_cnt[i]  <= 0;
            m_clk[i]  <= !m_clk[i];
            m_tick[i] <= 1'b1;
            if (m_busy[i]) begin
              m_act[i]  <= m_pend[i];
              m_busy[i] <= 1'b0;
            end
          end else begin
            m_tick[i] <= 1'b0;
            if (ev) m_cnt[i] <= m_cnt[i] + 1;
          end
          if (wr) begin
            m_pend[i] <= int'(div_val);
            m_busy[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin : cmp
      logic [NCH-1:0] ec;
      logic [NCH-1:0] et;
      logic [NCH-1:0] eb;
      for (int i = 0; i < NCH; i++) begin
        ec[i] = m_clk[i];
        et[i] = m_tick[i];
        eb[i] = m_busy[i];
      end
      chk("model_clk_out", clk_out, ec);
      chk("model_tick", tick, et);
      chk("model_div_busy", div_busy, eb);
    end
  end

  // Counts negedges until tick[ch] is seen high.
  task automatic tick_gap(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick[ch] && n < LIMIT);
  endtask

  // Counts negedges until the next rising edge of clk_out[ch].
  task automatic rise_gap(input int ch, output int n);
    logic prev;
    bit   hit;
    hit  = 1'b0;
    n    = 0;
    prev = clk_out[ch];
    while (!hit && n < LIMIT) begin
      @(negedge clk);
      n++;
      hit  = clk_out[ch] && !prev;
      prev = clk_out[ch];
    end
  endtask

  task automatic wr(input int sel, input int val);
    div_wr  = 1'b1;
    div_sel = 2'(sel);
    div_val = CW'(val);
    @(negedge clk);
    div_wr  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    enable  = '0;
    div_wr  = 1'b0;
    div_sel = '0;
    div_val = '0;
`ifdef CLK_DIV_BANK_SYNC_EN
    sync_rst = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_div_busy", div_busy, 0);

    // Release with the default divisor.
    enable = '1;
    rst_n  = 1'b1;
    tick_gap(0, n);
    chk("first_tick0_cycles", n, DEF_DIV);
    chk("first_tick2_coincident", tick[2], 1);

    // Program the divisors while idle. Each write applies on the following cycle.
    enable = '0;
    @(negedge clk);
    wr(3, 1);
    chk("oob_sel_ignored", div_busy, 0);
    wr(0, 2);
    chk("idle_wr_busy0", div_busy, 3'b001);
    wr(1, 3);
    chk("idle_apply0_busy1", div_busy, 3'b010);
    wr(2, 4);
    chk("idle_apply1_busy2", div_busy, 3'b100);
    @(negedge clk);
    chk("idle_apply_all", div_busy, 0);
    enable = '1;
    tick_gap(0, n);
    tick_gap(0, n);
    chk("tick0_gap_d2", n, 2);
    rise_gap(0, n);
    rise_gap(0, n);
    chk("clk0_period_d2", n, 4);
    tick_gap(1, n);
    tick_gap(1, n);
    chk("tick1_gap_chain", n, 6);
    rise_gap(1, n);
    rise_gap(1, n);
    chk("clk1_period_chain", n, 12);

    // Change a running divisor from 4 to 6 mid-count.
    wr(0, 4);
    repeat (8) @(negedge clk);
    chk("d4_applied", div_busy[0], 0);
    tick_gap(0, n);
    @(negedge clk);
    wr(0, 6);
    chk("busy_after_wr", div_busy[0], 1);
    @(negedge clk);
    chk("busy_hold", div_busy[0], 1);
    chk("no_early_tick", tick[0], 0);
    @(negedge clk);
    chk("busy_clear_at_wrap", div_busy[0], 0);
    chk("changeover_tick", tick[0], 1);
    tick_gap(0, n);
    chk("tick0_gap_d6", n, 6);
    rise_gap(0, n);
    rise_gap(0, n);
    chk("clk0_period_d6", n, 12);

    // Park ch0 with D=0. The chained ch1 freezes.
    wr(0, 0);
    repeat (12) @(negedge clk);
    chk("d0_clk_low", clk_out[0], 0);
    chk("d0_no_tick", tick[0], 0);
    chk("d0_applied", div_busy[0], 0);
    repeat (10) @(negedge clk);
    chk("ch1_frozen_tick", tick[1], 0);
    wr(0, 3);
    chk("parked_wr_busy", div_busy[0], 1);
    @(negedge clk);
    chk("parked_apply", div_busy[0], 0);
    tick_gap(0, n);
    chk("resume_first_wrap", n, 3);

    // Drop the enable mid-count, then re-enable.
    @(negedge clk);
    enable[0] = 1'b0;
    @(negedge clk);
    chk("disable_clk_low", clk_out[0], 0);
    enable[0] = 1'b1;
    tick_gap(0, n);
    chk("reenable_first_wrap", n, 3);

    // Asynchronous reset between edges discards the pending write.
    wr(2, 7);
    chk("pending_before_rst", div_busy, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clk_out", clk_out, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_busy", div_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick_gap(2, n);
    chk("post_rst_default_div", n, DEF_DIV);

`ifdef CLK_DIV_BANK_SYNC_EN
    wr(0, 5);
    wr(2, 5);
    repeat (7) @(negedge clk);
    sync_rst = 1'b1;
    div_wr   = 1'b1;
    div_sel  = 2'd1;
    div_val  = CW'(9);
    @(negedge clk);
    sync_rst = 1'b0;
    div_wr   = 1'b0;
    chk("sync_clk_out", clk_out, 0);
    chk("sync_tick", tick, 0);
    chk("sync_busy_wr_dropped", div_busy, 0);
    tick_gap(0, n);
    chk("sync_tick0_d5", n, 5);
    chk("sync_tick2_coincident", tick[2], 1);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) enable[i] = ($urandom_range(0, 19) != 0);
      div_wr  = ($urandom_range(0, 5) == 0);
      div_sel = 2'($urandom_range(0, 3));
      div_val = CW'($urandom_range(0, 9));
`ifdef CLK_DIV_BANK_SYNC_EN
      sync_rst = ($urandom_range(0, 63) == 0);
`endif
      @(negedge clk);
    end
    div_wr = 1'b0;
`ifdef CLK_DIV_BANK_SYNC_EN
    sync_rst = 1'b0;
`endif
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
